axi_lite_sram: RTL and testbench
================================

Name: axi_lite_sram

Overview:
- AXI-lite responder backed by an on-chip word-addressed memory. It is the slave end of the bus driven by the LSU/IFU arbiter.
- Services one read and one write transaction concurrently, on independent read and write channels.
- Read and write response latencies are programmable, so the core can be exercised against slow memory.
- Out-of-range accesses are answered with DECERR and have no side effects.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH, 4096, number of DATA_WIDTH words; must be a power of two.
- RD_LATENCY, 1, extra wait cycles between AR handshake and rvalid (0..15).
- WR_LATENCY, 1, extra wait cycles between AW+W capture and bvalid (0..15).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- araddr_i  in  ADDR_WIDTH  read address.
- arvalid_i  in  1  read address valid.
- arready_o  out  1  read address ready.
- rdata_o  out  DATA_WIDTH  read data.
- rresp_o  out  2  read response.
- rvalid_o  out  1  read data valid.
- rready_i  in  1  read data ready.
- awaddr_i  in  ADDR_WIDTH  write address.
- awvalid_i  in  1  write address valid.
- awready_o  out  1  write address ready.
- wdata_i  in  DATA_WIDTH  write data.
- wstrb_i  in  STRB_WIDTH  byte enables.
- wvalid_i  in  1  write data valid.
- wready_o  out  1  write data ready.
- bresp_o  out  2  write response.
- bvalid_o  out  1  write response valid.
- bready_i  in  1  write response ready.

Behaviour:
- Single clock clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - Read FSM in R_IDLE, write FSM in W_IDLE.
  - arready_o=1, awready_o=1, wready_o=1.
  - rvalid_o=0, bvalid_o=0, rdata_o=0, rresp_o=OKAY, bresp_o=OKAY.
  - Memory contents are not reset.
- Address decode:
  - off = addr - BASE_ADDR; hit when off < DEPTH*4.
  - Word index = off[log2(DEPTH)+1:2]; addr[1:0] is ignored (accesses are word-aligned).
  - Miss gives DECERR (2'b11), rdata 0, no write. Hit gives OKAY (2'b00).
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready_o=1. On arvalid_i, latch address and load cnt=RD_LATENCY. Go to R_WAIT, or to R_RESP if RD_LATENCY=0.
  - R_WAIT: arready_o=0. Decrement cnt each cycle; go to R_RESP when cnt reaches 1.
  - R_RESP:
    - rdata_o/rresp_o are registered on entry and held stable while rvalid_o=1, independent of later writes.
    - rvalid_o=1 until rready_i, then return to R_IDLE.
    - arready_o rises the cycle after the R handshake.
  - Latency: rvalid_o asserts RD_LATENCY+1 cycles after the AR handshake.
  - arvalid_i held high after its handshake (masters keep it high until the response) must never start a second read.
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
  - W_IDLE captures AW and W independently. awready_o drops after AW is captured; wready_o drops after W is captured.
  - When both are held (same cycle or different cycles), load cnt=WR_LATENCY and enter W_WAIT.
  - W_WAIT: at cnt expiry, commit the write with per-byte strobes (only bytes with wstrb bit set change), register bresp, enter W_RESP.
  - W_RESP: bvalid_o=1 until bready_i. Return to W_IDLE with both readies high the next cycle.
  - Latency: bvalid_o asserts WR_LATENCY+1 cycles after the later of the AW/W handshakes.
- Write commit timing:
  - The commit happens on the clock edge that enters W_RESP.
  - wstrb=0 on a hit still returns OKAY and changes no bytes.
- Simultaneous read and write to the same word: the read samples memory on the edge entering R_RESP.
  - If the write commit is on the same edge, the read returns the old data (read-before-write).
- rready_i/bready_i held high before the valid rises: the handshake completes in the first valid cycle. Minimum occupancy in R_RESP/W_RESP is one cycle.
- Reset mid-transaction: pending transactions are dropped and no response is issued. A write not yet committed never reaches memory.

Decomposition:
- liang_pkg gains:
  - axi_resp_e (RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11).
  - Read-FSM and write-FSM state enums.
  - Existing ADDR_WIDTH/DATA_WIDTH/STRB_WIDTH are reused.
- One sub-module, axi_lite_mem_array:
  - DEPTH x DATA_WIDTH storage.
  - One combinational read port, one synchronous byte-strobed write port.

Test Plan:
- Read latency: preload word at 0x8000_0010 = 32'hDEAD_BEEF, RD_LATENCY=2. AR at cycle t -> rvalid_o at t+3 with rdata_o=DEADBEEF, rresp_o=OKAY. arready_o stays 0 until one cycle after the R handshake.
- Partial write: write 0x8000_0020 data 32'h1122_3344 strb 4'b0110 over initial 0 -> bresp OKAY. Readback gives 32'h0022_3300.
- Split AW/W: AW at t, W at t+3, WR_LATENCY=0 -> bvalid_o at t+4. Hold bready_i=0 for 5 cycles -> bvalid_o stays high and awready_o/wready_o stay 0 until the handshake.
- Out of range: read 0x7FFF_FFFC and write 0x8000_4000 (DEPTH=4096) -> rresp/bresp = 2'b11, rdata 0, memory unchanged.
- Same-word collision: read and write to the same word timed so the read samples on the commit edge -> read returns the old value; a subsequent read returns the new value.
- Mid-transaction reset: assert rst_ni low during W_WAIT -> bvalid_o=0 and the target word is unchanged. After release, all readies are 1.

Source files
------------

// File: rtl/liang_pkg.sv
// Shared bus widths, AXI response codes and FSM state encodings for the
// AXI-lite SRAM responder.
package liang_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_RESP
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_WAIT,
      W_RESP
   } wr_state_e;

endpackage

// File: rtl/axi_lite_mem_array.sv
// Word-addressed storage: combinational read port, synchronous byte-strobed
// write port. Contents are deliberately not reset.
module axi_lite_mem_array
   import liang_pkg::*;
#(
   parameter int DEPTH = 4096,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [IDX_W-1:0]      waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [STRB_WIDTH-1:0] wstrb_i,
   input  logic [IDX_W-1:0]      raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_lite_sram.sv
// AXI-lite slave backed by on-chip SRAM with independent read/write channels
// and programmable response latency; out-of-range accesses return DECERR.
module axi_lite_sram
   import liang_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
   parameter int                    DEPTH      = 4096,
   parameter int                    RD_LATENCY = 1,
   parameter int                    WR_LATENCY = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [ADDR_WIDTH-1:0] araddr_i,
   input  logic                  arvalid_i,
   output logic                  arready_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic [1:0]            rresp_o,
   output logic                  rvalid_o,
   input  logic                  rready_i,
   input  logic [ADDR_WIDTH-1:0] awaddr_i,
   input  logic                  awvalid_i,
   output logic                  awready_o,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [STRB_WIDTH-1:0] wstrb_i,
   input  logic                  wvalid_i,
   output logic                  wready_o,
   output logic [1:0]            bresp_o,
   output logic                  bvalid_o,
   input  logic                  bready_i
);

   localparam int                    IDX_W    = $clog2(DEPTH);
   localparam logic [3:0]            RD_LAT   = 4'(RD_LATENCY);
   localparam logic [3:0]            WR_LAT   = 4'(WR_LATENCY);
   localparam logic [ADDR_WIDTH-1:0] SPAN     = ADDR_WIDTH'(DEPTH * 4);

   rd_state_e             rstate_q, rstate_d;
   logic [3:0]            rcnt_q, rcnt_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   axi_resp_e             rresp_q, rresp_d;

   wr_state_e             wstate_q, wstate_d;
   logic [3:0]            wcnt_q, wcnt_d;
   logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
   axi_resp_e             bresp_q, bresp_d;

   logic [ADDR_WIDTH-1:0] rd_off, wr_off, wa_eff;
   logic [DATA_WIDTH-1:0] wd_eff, mem_rdata;
   logic [STRB_WIDTH-1:0] ws_eff;
   logic                  rd_hit, wr_hit, mem_we, aw_fire, w_fire;

   // In idle the read port looks straight at araddr_i so zero latency works.
   assign rd_off = ((rstate_q == R_IDLE) ? araddr_i : raddr_q) - BASE_ADDR;
   assign rd_hit = (rd_off < SPAN);
   assign wa_eff = aw_held_q ? awaddr_q : awaddr_i;
   assign wd_eff = w_held_q  ? wdata_q  : wdata_i;
   assign ws_eff = w_held_q  ? wstrb_q  : wstrb_i;
   assign wr_off = wa_eff - BASE_ADDR;
   assign wr_hit = (wr_off < SPAN);

   axi_lite_mem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
      .clk_i   (clk_i),
      .we_i    (mem_we),
      .waddr_i (wr_off[IDX_W+1:2]),
      .wdata_i (wd_eff),
      .wstrb_i (ws_eff),
      .raddr_i (rd_off[IDX_W+1:2]),
      .rdata_o (mem_rdata)
   );

   always_comb begin
      rstate_d  = rstate_q;
      rcnt_d    = rcnt_q;
      raddr_d   = raddr_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      arready_o = 1'b0;
      rvalid_o  = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            arready_o = 1'b1;
            if (arvalid_i) begin
               raddr_d = araddr_i;
               rcnt_d  = RD_LAT;
               if (RD_LAT == 4'd0) begin
                  rstate_d = R_RESP;
                  rdata_d  = rd_hit ? mem_rdata : '0;
                  rresp_d  = rd_hit ? RESP_OKAY : RESP_DECERR;
               end else begin
                  rstate_d = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            rcnt_d = rcnt_q - 4'd1;
            if (rcnt_q <= 4'd1) begin
               rstate_d = R_RESP;
               rdata_d  = rd_hit ? mem_rdata : '0;
               rresp_d  = rd_hit ? RESP_OKAY : RESP_DECERR;
            end
         end
         R_RESP: begin
            rvalid_o = 1'b1;
            if (rready_i) rstate_d = R_IDLE;
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_comb begin
      wstate_d  = wstate_q;
      wcnt_d    = wcnt_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      awready_o = 1'b0;
      wready_o  = 1'b0;
      bvalid_o  = 1'b0;
      mem_we    = 1'b0;
      aw_fire   = 1'b0;
      w_fire    = 1'b0;
      case (wstate_q)
         W_IDLE: begin
            awready_o = ~aw_held_q;
            wready_o  = ~w_held_q;
            aw_fire   = awvalid_i & ~aw_held_q;
            w_fire    = wvalid_i & ~w_held_q;
            if (aw_fire) begin
               aw_held_d = 1'b1;
               awaddr_d  = awaddr_i;
            end
            if (w_fire) begin
               w_held_d = 1'b1;
               wdata_d  = wdata_i;
               wstrb_d  = wstrb_i;
            end
            if ((aw_held_q | aw_fire) && (w_held_q | w_fire)) begin
               wcnt_d = WR_LAT;
               if (WR_LAT == 4'd0) begin
                  mem_we   = wr_hit;
                  bresp_d  = wr_hit ? RESP_OKAY : RESP_DECERR;
                  wstate_d = W_RESP;
               end else begin
                  wstate_d = W_WAIT;
               end
            end
         end
         W_WAIT: begin
            wcnt_d = wcnt_q - 4'd1;
            if (wcnt_q <= 4'd1) begin
               mem_we   = wr_hit;
               bresp_d  = wr_hit ? RESP_OKAY : RESP_DECERR;
               wstate_d = W_RESP;
            end
         end
         W_RESP: begin
            bvalid_o = 1'b1;
            if (bready_i) begin
               wstate_d  = W_IDLE;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rstate_q  <= R_IDLE;
         rcnt_q    <= '0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         wstate_q  <= W_IDLE;
         wcnt_q    <= '0;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         rstate_q  <= rstate_d;
         rcnt_q    <= rcnt_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         wstate_q  <= wstate_d;
         wcnt_q    <= wcnt_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         bresp_q   <= bresp_d;
      end
   end

   always_ff @(posedge clk_i) begin
      raddr_q  <= raddr_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
   end

   assign rdata_o = rdata_q;
   assign rresp_o = rresp_q;
   assign bresp_o = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram.sv
// Directed bench: instance A (RD_LATENCY=2, WR_LATENCY=0) covers latency,
// strobes, split AW/W, decode errors and collisions; instance B covers reset.
module tb_axi_lite_sram;

   logic        clk = 1'b0;
   logic        rst_n, rst_b_n;
   int          n_err = 0;
   int          n_chk = 0;

   logic [31:0] araddr, awaddr, wdata;
   logic [3:0]  wstrb;
   logic        arvalid, rready, awvalid, wvalid, bready;
   logic        arready, rvalid, awready, wready, bvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp, bresp;

   logic [31:0] b_araddr, b_awaddr, b_wdata;
   logic [3:0]  b_wstrb;
   logic        b_arvalid, b_rready, b_awvalid, b_wvalid, b_bready;
   logic        b_arready, b_rvalid, b_awready, b_wready, b_bvalid;
   logic [31:0] b_rdata;
   logic [1:0]  b_rresp, b_bresp;

   logic [31:0] d;
   logic [1:0]  r;

   always #5 clk = ~clk;

   axi_lite_sram #(.RD_LATENCY(2), .WR_LATENCY(0)) dut_a (
      .clk_i(clk), .rst_ni(rst_n),
      .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
      .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
      .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
      .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
      .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready)
   );

   axi_lite_sram dut_b (
      .clk_i(clk), .rst_ni(rst_b_n),
      .araddr_i(b_araddr), .arvalid_i(b_arvalid), .arready_o(b_arready),
      .rdata_o(b_rdata), .rresp_o(b_rresp), .rvalid_o(b_rvalid), .rready_i(b_rready),
      .awaddr_i(b_awaddr), .awvalid_i(b_awvalid), .awready_o(b_awready),
      .wdata_i(b_wdata), .wstrb_i(b_wstrb), .wvalid_i(b_wvalid), .wready_o(b_wready),
      .bresp_o(b_bresp), .bvalid_o(b_bvalid), .bready_i(b_bready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr_a(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                       output logic [1:0] resp);
      awaddr = a; wdata = dat; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      for (int i = 0; i < 40 && !bvalid; i++) tick();
      chk("wr_bvalid_seen", {31'd0, bvalid}, 32'd1);
      resp = bresp;
      bready = 1'b1;
      tick();
      bready = 1'b0;
   endtask

   task automatic rd_a(input logic [31:0] a, output logic [31:0] dat, output logic [1:0] resp);
      araddr = a; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      for (int i = 0; i < 40 && !rvalid; i++) tick();
      chk("rd_rvalid_seen", {31'd0, rvalid}, 32'd1);
      dat = rdata; resp = rresp;
      rready = 1'b1;
      tick();
      rready = 1'b0;
   endtask

   initial begin
      araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
      arvalid = 0; rready = 0; awvalid = 0; wvalid = 0; bready = 0;
      b_araddr = '0; b_awaddr = '0; b_wdata = '0; b_wstrb = '0;
      b_arvalid = 0; b_rready = 0; b_awvalid = 0; b_wvalid = 0; b_bready = 0;
      rst_n = 1'b0; rst_b_n = 1'b0;
      tick(); tick();
      chk("rst_arready", {31'd0, arready}, 32'd1);
      chk("rst_awready", {31'd0, awready}, 32'd1);
      chk("rst_wready",  {31'd0, wready},  32'd1);
      chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
      chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
      chk("rst_rdata",   rdata, 32'd0);
      chk("rst_rresp",   {30'd0, rresp}, 32'd0);
      chk("rst_bresp",   {30'd0, bresp}, 32'd0);
      rst_n = 1'b1; rst_b_n = 1'b1;
      tick();

      // Preload
      wr_a(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r);
      chk("preload_bresp", {30'd0, r}, 32'd0);
      wr_a(32'h8000_0000, 32'h5A5A_0000, 4'hF, r);
      wr_a(32'h8000_0020, 32'h0000_0000, 4'hF, r);

      // Read latency: arvalid held until the response
      araddr = 32'h8000_0010; arvalid = 1'b1;
      tick();
      chk("lat_rvalid_t1", {31'd0, rvalid}, 32'd0);
      chk("lat_arready_t1", {31'd0, arready}, 32'd0);
      tick();
      chk("lat_rvalid_t2", {31'd0, rvalid}, 32'd0);
      tick();
      chk("lat_rvalid_t3", {31'd0, rvalid}, 32'd1);
      chk("lat_rdata", rdata, 32'hDEAD_BEEF);
      chk("lat_rresp", {30'd0, rresp}, 32'd0);
      chk("lat_arready_t3", {31'd0, arready}, 32'd0);
      tick();
      chk("lat_rvalid_hold", {31'd0, rvalid}, 32'd1);
      chk("lat_rdata_hold", rdata, 32'hDEAD_BEEF);
      rready = 1'b1; arvalid = 1'b0;
      tick();
      rready = 1'b0;
      chk("lat_rvalid_done", {31'd0, rvalid}, 32'd0);
      chk("lat_arready_back", {31'd0, arready}, 32'd1);

      // Partial write and zero-strobe write
      wr_a(32'h8000_0020, 32'h1122_3344, 4'b0110, r);
      chk("pw_bresp", {30'd0, r}, 32'd0);
      rd_a(32'h8000_0020, d, r);
      chk("pw_readback", d, 32'h0022_3300);
      wr_a(32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, r);
      chk("zs_bresp", {30'd0, r}, 32'd0);
      rd_a(32'h8000_0023, d, r);
      chk("zs_readback", d, 32'h0022_3300);

      // Split AW/W with bready held low
      awaddr = 32'h8000_0030; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("split_awready", {31'd0, awready}, 32'd0);
      chk("split_wready", {31'd0, wready}, 32'd1);
      chk("split_bvalid_early", {31'd0, bvalid}, 32'd0);
      tick();
      tick();
      wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk("split_bvalid_t4", {31'd0, bvalid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("split_hold_bvalid", {31'd0, bvalid}, 32'd1);
         chk("split_hold_readies", {30'd0, awready, wready}, 32'd0);
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("split_bvalid_done", {31'd0, bvalid}, 32'd0);
      chk("split_readies_back", {30'd0, awready, wready}, 32'd3);
      rd_a(32'h8000_0030, d, r);
      chk("split_readback", d, 32'hCAFE_F00D);

      // Out of range
      rd_a(32'h7FFF_FFFC, d, r);
      chk("oor_rresp", {30'd0, r}, 32'd3);
      chk("oor_rdata", d, 32'd0);
      wr_a(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, r);
      chk("oor_bresp", {30'd0, r}, 32'd3);
      rd_a(32'h8000_0000, d, r);
      chk("oor_mem_unchanged", d, 32'h5A5A_0000);

      // Same-word collision: write commits on the edge the read samples
      araddr = 32'h8000_0010; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      tick();
      awaddr = 32'h8000_0010; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("col_rvalid", {31'd0, rvalid}, 32'd1);
      chk("col_bvalid", {31'd0, bvalid}, 32'd1);
      chk("col_old_data", rdata, 32'hDEAD_BEEF);
      rready = 1'b1; bready = 1'b1;
      tick();
      rready = 1'b0; bready = 1'b0;
      rd_a(32'h8000_0010, d, r);
      chk("col_new_data", d, 32'h0BAD_F00D);

      // Instance B: reset during W_WAIT drops the write
      b_awaddr = 32'h8000_0040; b_wdata = 32'h1234_5678; b_wstrb = 4'hF;
      b_awvalid = 1'b1; b_wvalid = 1'b1;
      tick();
      b_awvalid = 1'b0; b_wvalid = 1'b0;
      chk("b_bvalid_wait", {31'd0, b_bvalid}, 32'd0);
      tick();
      chk("b_bvalid_lat", {31'd0, b_bvalid}, 32'd1);
      b_bready = 1'b1;
      tick();
      b_bready = 1'b0;
      b_wdata = 32'hFFFF_FFFF; b_awvalid = 1'b1; b_wvalid = 1'b1;
      tick();
      b_awvalid = 1'b0; b_wvalid = 1'b0;
      chk("b_in_wait", {29'd0, b_bvalid, b_awready, b_wready}, 32'd0);
      rst_b_n = 1'b0;
      #1;
      chk("b_rst_bvalid", {31'd0, b_bvalid}, 32'd0);
      tick();
      tick();
      rst_b_n = 1'b1;
      tick();
      chk("b_rel_readies", {29'd0, b_arready, b_awready, b_wready}, 32'd7);
      chk("b_rel_bvalid", {31'd0, b_bvalid}, 32'd0);
      b_araddr = 32'h8000_0040; b_arvalid = 1'b1;
      tick();
      b_arvalid = 1'b0;
      tick();
      chk("b_rd_rvalid", {31'd0, b_rvalid}, 32'd1);
      chk("b_rd_unchanged", b_rdata, 32'h1234_5678);
      b_rready = 1'b1;
      tick();
      b_rready = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
